// File: rtl/pwm_generator_pkg.sv
// Shared defaults and width helper for the PWM generator and its button front end.
// Pure constants and a constant function; no logic, no latency, no backpressure.
package pwm_generator_pkg;

  localparam int PWM_PERIOD_DEF       = 10;
  localparam int PWM_DUTY_INIT_DEF    = 5;
  localparam int PWM_DEBOUNCE_DIV_DEF = 2;

  // ceil(log2(n)) but never below 1, so degenerate parameters still give a legal vector.
  function automatic int pwm_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/pwm_button_debounce.sv
// Raw button -> 2-FF sync -> two-sample debounce on a divided tick -> one-cycle rising-edge step.
// Latency 2 + up to 2*DEBOUNCE_DIV cycles from pin to step; free-running, no backpressure.
module pwm_button_debounce
  import pwm_generator_pkg::*;
#(
  parameter int DEBOUNCE_DIV = PWM_DEBOUNCE_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic step
);

  localparam int              TW        = pwm_width(DEBOUNCE_DIV);
  localparam logic [TW-1:0]   TICK_LAST = TW'(DEBOUNCE_DIV - 1);

  logic [1:0]    sync;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          sample_prev;
  logic          level;
  logic          level_d;

  assign tick = (tick_cnt == TICK_LAST);
  assign step = level & ~level_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync        <= 2'b00;
      tick_cnt    <= '0;
      sample_prev <= 1'b0;
      level       <= 1'b0;
      level_d     <= 1'b0;
    end else begin
      sync     <= {sync[0], btn};
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      // Level only moves when two consecutive tick samples agree.
      if (tick) begin
        sample_prev <= sync[1];
        if (sync[1] == sample_prev) level <= sync[1];
      end
      level_d <= level;
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// Fixed-period PWM with button-stepped duty; duty changes land only on a period boundary.
// Output is one register after the period counter; buttons are free-running inputs, no backpressure.
module pwm_generator
  import pwm_generator_pkg::*;
#(
  parameter int PERIOD       = PWM_PERIOD_DEF,
  parameter int DUTY_INIT    = PWM_DUTY_INIT_DEF,
  parameter int DEBOUNCE_DIV = PWM_DEBOUNCE_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic increase_duty,
  input  logic decrease_duty,
  output logic PWM_OUT
);

  localparam int            DW       = pwm_width(PERIOD + 1);
  localparam int            CW       = pwm_width(PERIOD);
  localparam logic [DW-1:0] DUTY_MAX = DW'(PERIOD);
  localparam logic [DW-1:0] DUTY_RST = DW'(DUTY_INIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  logic [DW-1:0] duty;
  logic [DW-1:0] duty_shadow;
  logic [CW-1:0] cnt;
  logic          inc_step;
  logic          dec_step;

  pwm_button_debounce #(.DEBOUNCE_DIV(DEBOUNCE_DIV)) u_inc_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (increase_duty),
    .step  (inc_step)
  );

  pwm_button_debounce #(.DEBOUNCE_DIV(DEBOUNCE_DIV)) u_dec_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (decrease_duty),
    .step  (dec_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      duty        <= DUTY_RST;
      duty_shadow <= DUTY_RST;
      PWM_OUT     <= 1'b0;
    end else begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      if (cnt == CNT_LAST) duty_shadow <= duty;
      // Simultaneous steps cancel; both directions saturate instead of wrapping.
      if (inc_step && !dec_step && duty != DUTY_MAX) duty <= duty + DW'(1);
      else if (dec_step && !inc_step && duty != '0) duty <= duty - DW'(1);
      PWM_OUT <= (DW'(cnt) < duty_shadow);
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Randomized bench for pwm_generator: a press-count duty model and period-position tracker
// predict the high/low pattern of every observed PWM period.
module tb_pwm_generator;

  localparam int P         = 10;
  localparam int DUTY_INIT = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic inc_btn;
  logic dec_btn;
  logic pwm_out;

  pwm_generator #(
    .PERIOD       (P),
    .DUTY_INIT    (DUTY_INIT),
    .DEBOUNCE_DIV (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .increase_duty (inc_btn),
    .decrease_duty (dec_btn),
    .PWM_OUT       (pwm_out)
  );

  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int duty_m;     // duty the model expects after all accepted presses
  int mcnt;       // position within the period the next clock edge will present
  int out_phase;  // period position shown by the latest sample, -1 while in reset

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step_clk();
    @(posedge clk);
    #1;
    if (rst_n) begin
      out_phase = mcnt;
      mcnt      = (mcnt + 1) % P;
    end else begin
      out_phase = -1;
      mcnt      = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step_clk();
  endtask

  // High for the first d positions of a period, low for the rest.
  function automatic int exp_pattern(input int d);
    int p;
    p = 0;
    for (int i = 0; i < P; i++)
      if (i < d) p = p | (1 << i);
    return p;
  endfunction

  function automatic int next_duty(input int d, input bit up, input bit dn);
    if (up && !dn) return (d < P) ? d + 1 : P;
    if (dn && !up) return (d > 0) ? d - 1 : 0;
    return d;
  endfunction

  // Capture one full output period starting at position 0; buttons are driven
  // to inc_v/dec_v right after the first sample and dropped at the end.
  task automatic grab_period(input logic inc_v, input logic dec_v, output int pat);
    int guard;
    guard = 0;
    pat   = 0;
    step_clk();
    while (out_phase != 0 && guard < 3 * P) begin
      step_clk();
      guard++;
    end
    if (out_phase != 0) begin
      check("period_align_timeout", out_phase, 0);
      pat = -1;
    end else begin
      inc_btn = inc_v;
      dec_btn = dec_v;
      if (pwm_out === 1'b1) pat = pat | 1;
      for (int i = 1; i < P; i++) begin
        step_clk();
        if (pwm_out === 1'b1) pat = pat | (1 << i);
      end
      inc_btn = 1'b0;
      dec_btn = 1'b0;
    end
  endtask

  task automatic check_duty(input string tag);
    int pat;
    grab_period(1'b0, 1'b0, pat);
    check(tag, pat, exp_pattern(duty_m));
  endtask

  task automatic press(input logic inc_v, input logic dec_v, input int hi, input int lo);
    inc_btn = inc_v;
    dec_btn = dec_v;
    repeat (hi) step_clk();
    inc_btn = 1'b0;
    dec_btn = 1'b0;
    repeat (lo) step_clk();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pat;
    int op;
    bit up;
    bit dn;
    n_vec     = 0;
    n_err     = 0;
    duty_m    = DUTY_INIT;
    mcnt      = 0;
    out_phase = -1;
    rst_n     = 1'b0;
    inc_btn   = 1'b0;
    dec_btn   = 1'b0;

    idle(3);
    check("reset_pwm_low", {31'b0, pwm_out}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 50; i++) check_duty("idle_default_duty");

    for (int i = 0; i < 3; i++) begin
      press(1'b1, 1'b0, 10, 10);
      duty_m = next_duty(duty_m, 1'b1, 1'b0);
    end
    check_duty("three_inc");

    // Duty change requested mid-period: running period keeps the old duty.
    grab_period(1'b0, 1'b1, pat);
    check("mid_period_dec_old", pat, exp_pattern(duty_m));
    duty_m = next_duty(duty_m, 1'b0, 1'b1);
    idle(12);
    check_duty("mid_period_dec_new");
    grab_period(1'b1, 1'b0, pat);
    check("mid_period_inc_old", pat, exp_pattern(duty_m));
    duty_m = next_duty(duty_m, 1'b1, 1'b0);
    idle(12);
    check_duty("mid_period_inc_new");

    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b1, 10, 10);
      duty_m = next_duty(duty_m, 1'b0, 1'b1);
    end
    check_duty("three_dec");

    for (int i = 0; i < 3; i++) begin
      press(1'b1, 1'b0, 10, 10);
      duty_m = next_duty(duty_m, 1'b1, 1'b0);
    end
    check_duty("pre_reset_duty");
    idle($urandom_range(1, 8));
    rst_n = 1'b0;
    step_clk();
    check("mid_period_reset_pwm", {31'b0, pwm_out}, 0);
    rst_n  = 1'b1;
    duty_m = DUTY_INIT;
    for (int i = 0; i < 3; i++) check_duty("after_reset");

    for (int i = 0; i < 7; i++) begin
      press(1'b1, 1'b0, 10, 10);
      duty_m = next_duty(duty_m, 1'b1, 1'b0);
      check_duty("saturate_high");
    end
    for (int i = 0; i < 12; i++) begin
      press(1'b0, 1'b1, 10, 10);
      duty_m = next_duty(duty_m, 1'b0, 1'b1);
      check_duty("saturate_low");
    end
    for (int i = 0; i < 5; i++) begin
      press(1'b1, 1'b0, 10, 10);
      duty_m = next_duty(duty_m, 1'b1, 1'b0);
    end
    check_duty("back_to_default");

    press(1'b1, 1'b0, 1000, 12);
    duty_m = next_duty(duty_m, 1'b1, 1'b0);
    check_duty("long_hold_one_step");
    check_duty("long_hold_stable");

    press(1'b1, 1'b0, 2, 12);
    check_duty("glitch_rejected");

    press(1'b1, 1'b1, 10, 10);
    check_duty("both_buttons_cancel");

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      if (op == 3) begin
        up = $urandom_range(0, 1);
        press(up, !up, $urandom_range(1, 2), 12);
      end else begin
        up = (op == 0) || (op == 2);
        dn = (op == 1) || (op == 2);
        press(up, dn, $urandom_range(10, 16), $urandom_range(10, 16));
        duty_m = next_duty(duty_m, up, dn);
      end
      check_duty("random_op");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
